// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the packet-aware FIFO read scheduler.
// Each FIFO head word is {eop, data}; the flattened read-data bus packs
// queue q at bit offset q*(DATA_WIDTH+1).
package fifo_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int SKID_DEPTH = 2;

   // EOP flag sits directly above the payload in each head word.
   function automatic int eop_bit(input int data_width);
      return data_width;
   endfunction

   // LSB position of queue q's head word inside the flattened read-data bus.
   function automatic int word_lsb(input int q, input int data_width);
      return q * (data_width + 1);
   endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_arb.sv
// Combinational arbiter: picks one requesting queue.
// Default build: round-robin, first request strictly after rr_ptr (wrapping).
// With STRICT_PRIO_EN defined: lowest-index requester wins, rr_ptr ignored.
module rr_arb
   import fifo_sched_pkg::*;
#(
   parameter int N_QUEUE = 4,
   parameter int QID_W   = $clog2(N_QUEUE)
) (
   input  logic [N_QUEUE-1:0] req,
   input  logic [QID_W-1:0]   rr_ptr,
   output logic [N_QUEUE-1:0] gnt_oh,
   output logic [QID_W-1:0]   gnt_idx
);

   int   idx;
   logic found;

`ifdef STRICT_PRIO_EN
   logic unused_rr_ptr;
   assign unused_rr_ptr = ^rr_ptr;

   // Lowest-index requesting queue wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_QUEUE; i++) begin
         idx = i;
         if (!found && req[idx[QID_W-1:0]]) begin
            found                   = 1'b1;
            gnt_idx                 = idx[QID_W-1:0];
            gnt_oh[idx[QID_W-1:0]]  = 1'b1;
         end
      end
   end
`else
   // Scan starting one past rr_ptr so the last-served queue goes to the back.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= N_QUEUE; i++) begin
         idx = (int'(rr_ptr) + i) % N_QUEUE;
         if (!found && req[idx[QID_W-1:0]]) begin
            found                   = 1'b1;
            gnt_idx                 = idx[QID_W-1:0];
            gnt_oh[idx[QID_W-1:0]]  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/fifo_rd_sched.sv
// Packet-aware read scheduler for N FWFT FIFO read ports.
// Grants one queue at a time, pops whole packets (EOP in word MSB) and
// streams them through a 2-entry skid buffer onto one valid/ready output.
// Build option: STRICT_PRIO_EN selects fixed-priority arbitration.
//
// Output handshake: a word transfers on a rising rd_clk_i when m_valid_o and
// m_ready_i are both high; m_data_o/m_last_o/m_qid_o hold steady while
// m_valid_o is high and m_ready_i is low. busy_o mirrors the FSM (1 = XFER).
module fifo_rd_sched
   import fifo_sched_pkg::*;
#(
   parameter int N_QUEUE    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int QID_W      = $clog2(N_QUEUE)
) (
   input  logic                              rd_clk_i,
   input  logic                              rstn_i,
   input  logic [N_QUEUE-1:0]                q_en_i,
   input  logic [N_QUEUE-1:0]                rd_empty_i,
   input  logic [N_QUEUE*(DATA_WIDTH+1)-1:0] rd_data_i,
   output logic [N_QUEUE-1:0]                rd_en_o,
   output logic                              m_valid_o,
   input  logic                              m_ready_i,
   output logic [DATA_WIDTH-1:0]             m_data_o,
   output logic                              m_last_o,
   output logic [QID_W-1:0]                  m_qid_o,
   output logic [QID_W-1:0]                  grant_o,
   output logic                              busy_o
);

   localparam int WORD_W = DATA_WIDTH + 1;
   localparam int EOP_B  = eop_bit(DATA_WIDTH);

   state_t                 state, next_state;
   logic [QID_W-1:0]       grant, rr_ptr, arb_idx;
   logic [N_QUEUE-1:0]     req, arb_oh;
   logic                   any_req, eop_pop, push, pop, skid_not_full;
   logic [WORD_W-1:0]      head_w [N_QUEUE];
   logic [WORD_W-1:0]      cur_w;

   logic [DATA_WIDTH-1:0]  skid_data [SKID_DEPTH];
   logic                   skid_last [SKID_DEPTH];
   logic [QID_W-1:0]       skid_qid  [SKID_DEPTH];
   logic                   wr_ptr, rd_ptr;
   logic [1:0]             count;

   for (genvar g = 0; g < N_QUEUE; g++) begin : g_head
      assign head_w[g] = rd_data_i[word_lsb(g, DATA_WIDTH) +: WORD_W];
   end

   assign req     = ~rd_empty_i & q_en_i;
   assign cur_w   = head_w[grant];
   assign any_req = |arb_oh;

   rr_arb #(
      .N_QUEUE (N_QUEUE),
      .QID_W   (QID_W)
   ) u_arb (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx)
   );

   // State, grant and round-robin pointer registers.
   always_ff @(posedge rd_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= QID_W'(N_QUEUE - 1);
      end else begin
         state <= next_state;
         if (state == IDLE && any_req) grant <= arb_idx;
         if (eop_pop) rr_ptr <= grant;
      end
   end

   // Next state and pop decode: only the granted, non-empty queue is popped,
   // and only while the skid has room.
   always_comb begin
      next_state = state;
      rd_en_o    = '0;
      eop_pop    = 1'b0;
      case (state)
         IDLE: if (any_req) next_state = XFER;
         XFER: begin
            if (!rd_empty_i[grant] && skid_not_full) begin
               rd_en_o[grant] = 1'b1;
               if (cur_w[EOP_B]) begin
                  eop_pop    = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign push          = |rd_en_o;
   assign pop           = m_valid_o & m_ready_i;
   assign skid_not_full = (count != 2'(SKID_DEPTH));

   // Two-entry skid FIFO; popped words are written the same cycle they are popped.
   always_ff @(posedge rd_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         count  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            skid_data[i] <= '0;
            skid_last[i] <= 1'b0;
            skid_qid[i]  <= '0;
         end
      end else begin
         if (push) begin
            skid_data[wr_ptr] <= cur_w[DATA_WIDTH-1:0];
            skid_last[wr_ptr] <= cur_w[EOP_B];
            skid_qid[wr_ptr]  <= grant;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign m_valid_o = (count != 2'd0);
   assign m_data_o  = skid_data[rd_ptr];
   assign m_last_o  = skid_last[rd_ptr];
   assign m_qid_o   = skid_qid[rd_ptr];
   assign grant_o   = grant;
   assign busy_o    = (state == XFER);

endmodule
